// File: rtl/arp_reply_tx_pkg.sv
// arp_reply_tx_pkg: ARP/Ethernet field constants, FPGA address defaults and reply FSM states
package arp_reply_tx_pkg;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
    localparam logic [7:0]  ARP_HLEN      = 8'h06;
    localparam logic [7:0]  ARP_PLEN      = 8'h04;
    localparam logic [47:0] DEF_SRC_MAC   = 48'h0023_551c_3565;
    localparam logic [31:0] DEF_SRC_IP    = 32'ha9fe_90e9;
    localparam int          DEF_FRAME_LEN = 60;
    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;
endpackage

// File: rtl/arp_frame_rom.sv
// arp_frame_rom: combinational byte-index to ARP reply byte mux; indices past the header read as pad zeros
module arp_frame_rom
    import arp_reply_tx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = DEF_SRC_MAC,
    parameter logic [31:0] SRC_IP  = DEF_SRC_IP
) (
    input  logic [5:0]  idx_i,
    input  logic [47:0] mac_i,
    input  logic [31:0] ip_i,
    output logic [7:0]  byte_o
);
    logic [41:0][7:0] hdr;
    assign hdr = {mac_i, SRC_MAC, ETH_TYPE_ARP, ARP_HTYPE_ETH, ETH_TYPE_IP, ARP_HLEN, ARP_PLEN,
                  ARP_OP_REPLY, SRC_MAC, SRC_IP, mac_i, ip_i};
    assign byte_o = idx_i < 6'd42 ? hdr[6'd41 - idx_i] : 8'h00;
endmodule

// File: rtl/arp_reply_tx.sv
// arp_reply_tx: builds a 60-byte ARP reply per request and streams it over the shared TX LocalLink port
module arp_reply_tx
    import arp_reply_tx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC   = DEF_SRC_MAC,
    parameter logic [31:0] SRC_IP    = DEF_SRC_IP,
    parameter int          FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arp,
    input  logic [47:0] arp_mac,
    input  logic [31:0] arp_ip,
    output logic        tx_req,
    input  logic        tx_gnt,
    output logic [7:0]  tx_data,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        tx_src_rdy,
    input  logic        tx_dst_rdy,
    output logic        busy,
    output logic        done,
    output logic [15:0] reply_count
);
    localparam logic [5:0] LAST = 6'(FRAME_LEN - 1);
    state_t      state_q;
    logic [5:0]  idx_q, idx_d;
    logic [47:0] mac_q, pmac_q;
    logic [31:0] ip_q, pip_q;
    logic        pend_q, req_q, sof_q, eof_q, rdy_q, done_q;
    logic [7:0]  data_q, rom_byte;
    logic [15:0] cnt_q;
    // rom looks up the byte that will be on the bus after the coming transfer
    assign idx_d = state_q == SEND ? idx_q + 6'd1 : 6'd0;
    arp_frame_rom #(.SRC_MAC(SRC_MAC), .SRC_IP(SRC_IP)) u_rom (
        .idx_i(idx_d), .mac_i(mac_q), .ip_i(ip_q), .byte_o(rom_byte)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sof_q   <= 1'b1;
            eof_q   <= 1'b1;
            rdy_q   <= 1'b1;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (arp && state_q != IDLE) begin
                pmac_q <= arp_mac;
                pip_q  <= arp_ip;
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (arp) begin
                    mac_q   <= arp_mac;
                    ip_q    <= arp_ip;
                    req_q   <= 1'b1;
                    state_q <= REQ;
                end
                REQ: if (tx_gnt) begin
                    idx_q   <= '0;
                    data_q  <= rom_byte;
                    sof_q   <= 1'b0;
                    eof_q   <= LAST != 6'd0;
                    rdy_q   <= 1'b0;
                    state_q <= SEND;
                end
                SEND: if (!tx_dst_rdy) begin
                    if (idx_q == LAST) begin
                        idx_q   <= '0;
                        data_q  <= '0;
                        sof_q   <= 1'b1;
                        eof_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= cnt_q + 16'd1;
                        state_q <= DONE;
                    end else begin
                        idx_q  <= idx_d;
                        data_q <= rom_byte;
                        sof_q  <= 1'b1;
                        eof_q  <= idx_d != LAST;
                    end
                end
                DONE: if (pend_q || arp) begin
                    // a request arriving now stays pending only if an older one is served first
                    mac_q   <= pend_q ? pmac_q : arp_mac;
                    ip_q    <= pend_q ? pip_q : arp_ip;
                    pend_q  <= pend_q && arp;
                    req_q   <= 1'b1;
                    state_q <= REQ;
                end else begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign tx_req      = req_q;
    assign tx_data     = data_q;
    assign tx_sof      = sof_q;
    assign tx_eof      = eof_q;
    assign tx_src_rdy  = rdy_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign reply_count = cnt_q;
endmodule

// File: tb/tb_arp_reply_tx.sv
// tb_arp_reply_tx: directed checks of the ARP reply transmitter against hand-built frames
module tb_arp_reply_tx;
    logic        clk = 1'b0, reset = 1'b1, arp = 1'b0, tx_gnt = 1'b1, tx_dst_rdy = 1'b0;
    logic [47:0] arp_mac = '0;
    logic [31:0] arp_ip = '0;
    logic        tx_req, tx_sof, tx_eof, tx_src_rdy, busy, done;
    logic [7:0]  tx_data;
    logic [15:0] reply_count;
    int          n_chk = 0, n_fail = 0;
    logic [7:0]  fb [64];
    logic [63:0] fsof, feof;
    int          nb, first_cyc, n_done;

    always #5 clk = ~clk;

    arp_reply_tx dut (
        .clk(clk), .reset(reset), .arp(arp), .arp_mac(arp_mac), .arp_ip(arp_ip),
        .tx_req(tx_req), .tx_gnt(tx_gnt), .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .tx_src_rdy(tx_src_rdy), .tx_dst_rdy(tx_dst_rdy), .busy(busy), .done(done),
        .reply_count(reply_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // called at a negedge; records transferred bytes until done (or until byte stop_at is on the bus)
    task automatic collect(input bit bp, input int stop_at, input int inj1, input logic [47:0] m1,
                           input int inj2, input logic [47:0] m2);
        int cyc = 0, herr = 0;
        bit stalled = 0, sent1 = 0, sent2 = 0, fin = 0;
        logic [9:0] prev = '0;
        nb = 0; first_cyc = -1; n_done = 0; fsof = '0; feof = '0;
        while (cyc < 600 && nb != stop_at) begin
            arp = 1'b0;
            if (nb == inj1 && !sent1) begin
                arp = 1'b1; arp_mac = m1; arp_ip = m1[31:0]; sent1 = 1;
            end
            if (nb == inj2 && !sent2) begin
                arp = 1'b1; arp_mac = m2; arp_ip = m2[31:0]; sent2 = 1;
            end
            tx_dst_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stalled && {tx_data, tx_sof, tx_eof} !== prev) herr++;
            if (nb > 0 && nb < 60 && tx_src_rdy) herr++;
            if (done && nb > 0) begin
                n_done++; fin = 1;
                break;
            end
            stalled = !tx_src_rdy && tx_dst_rdy;
            prev = {tx_data, tx_sof, tx_eof};
            if (!tx_src_rdy && !tx_dst_rdy) begin
                if (nb == 0) first_cyc = cyc;
                if (nb < 64) begin
                    fb[nb] = tx_data; fsof[nb] = !tx_sof; feof[nb] = !tx_eof;
                end
                nb++;
            end
            @(negedge clk);
            cyc++;
        end
        arp = 1'b0;
        tx_dst_rdy = 1'b0;
        check("hold_stable", herr, 0);
        if (stop_at < 0) check("frame_done", fin, 1);
    endtask

    task automatic check_frame(input string tag, input logic [47:0] mac, input logic [31:0] ip);
        logic [479:0] f;
        int bad = 0;
        f = {mac, 48'h0023_551c_3565, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
             48'h0023_551c_3565, 32'ha9fe_90e9, mac, ip, 144'h0};
        for (int i = 0; i < 60; i++) if (fb[i] !== f[479 - 8*i -: 8]) bad++;
        check({tag, "_len"}, nb, 60);
        check({tag, "_bytes"}, bad, 0);
        check({tag, "_sof"}, fsof, 64'h1);
        check({tag, "_eof"}, feof, 64'h1 << 59);
    endtask

    task automatic pulse(input logic [47:0] mac, input logic [31:0] ip);
        arp = 1'b1; arp_mac = mac; arp_ip = ip;
        @(negedge clk);
        arp = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, tx_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cnt"}, reply_count, 0);
        check({tag, "_ctl"}, {tx_sof, tx_eof, tx_src_rdy}, 3'b111);
        check({tag, "_data"}, tx_data, 0);
    endtask

    initial begin
        int bad;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        // single request, no backpressure
        arp = 1'b1; arp_mac = 48'h0011_2233_4455; arp_ip = 32'ha9fe_0001;
        check("t1_req_pre", tx_req, 0);
        @(negedge clk);
        arp = 1'b0;
        check("t1_req_n1", tx_req, 1);
        check("t1_busy", busy, 1);
        collect(0, -1, -1, '0, -1, '0);
        check("t1_first", first_cyc, 1);
        check_frame("t1", 48'h0011_2233_4455, 32'ha9fe_0001);
        check("t1_dmac", {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]}, 48'h0011_2233_4455);
        check("t1_etype", {fb[12], fb[13]}, 16'h0806);
        check("t1_op", {fb[20], fb[21]}, 16'h0002);
        check("t1_tip", {fb[38], fb[39], fb[40], fb[41]}, 32'ha9fe_0001);
        check("t1_done", done, 1);
        check("t1_req_drop", tx_req, 0);
        check("t1_cnt", reply_count, 1);
        @(negedge clk);
        check("t1_done_clr", done, 0);
        check("t1_idle", busy, 0);
        // random backpressure
        pulse(48'h0102_0304_0506, 32'hc0a8_0102);
        collect(1, -1, -1, '0, -1, '0);
        check_frame("t2", 48'h0102_0304_0506, 32'hc0a8_0102);
        check("t2_cnt", reply_count, 2);
        // grant held off for 20 cycles
        tx_gnt = 1'b0;
        pulse(48'h7766_5544_3322, 32'ha9fe_0002);
        bad = 0;
        repeat (20) begin
            if (!tx_req || !tx_src_rdy) bad++;
            @(negedge clk);
        end
        check("t3_gnt_wait", bad, 0);
        tx_gnt = 1'b1;
        collect(0, -1, -1, '0, -1, '0);
        check("t3_first", first_cyc, 1);
        check_frame("t3", 48'h7766_5544_3322, 32'ha9fe_0002);
        check("t3_cnt", reply_count, 3);
        // overlapping requests: latest pending wins
        pulse(48'h0a0b_0c0d_0e0f, 32'ha9fe_0003);
        collect(1, -1, 10, 48'hAAAA_BBBB_CCCC, 30, 48'h1212_3434_5656);
        check_frame("t4a", 48'h0a0b_0c0d_0e0f, 32'ha9fe_0003);
        check("t4a_cnt", reply_count, 4);
        collect(0, -1, -1, '0, -1, '0);
        check_frame("t4b", 48'h1212_3434_5656, 32'h3434_5656);
        check("t4b_cnt", reply_count, 5);
        @(negedge clk);
        check("t4_idle", busy, 0);
        // reset mid-frame with a request pending
        pulse(48'h5555_6666_7777, 32'ha9fe_0004);
        collect(0, 25, 10, 48'h9999_8888_7777, -1, '0);
        check("t5_stop", nb, 25);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("t5");
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || tx_req) bad++;
        end
        check("t5_no_pend", bad, 0);
        pulse(48'h0246_8ace_1357, 32'ha9fe_0044);
        collect(0, -1, -1, '0, -1, '0);
        check_frame("t5", 48'h0246_8ace_1357, 32'ha9fe_0044);
        check("t5_cnt", reply_count, 1);
        // counter wrap
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        check("t6_preload", reply_count, 16'hFFFF);
        pulse(48'h0000_0000_0001, 32'ha9fe_0005);
        collect(0, -1, -1, '0, -1, '0);
        check_frame("t6", 48'h0000_0000_0001, 32'ha9fe_0005);
        check("t6_wrap", reply_count, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
